// File: rtl/fetch_buf.sv
// fetch_buf: pipelined instruction-fetch front end feeding an in-order instruction queue.
// Latency: accepted request -> memory response (>=1 cycle) -> out_valid the following cycle.
// Backpressure: requests issue only while outstanding + queued < DEPTH, so a stalled out_ready throttles fetch without loss.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   redirect_valid/redirect_pc  flush queue, drop in-flight responses, restart fetch at redirect_pc
//   req_valid/req_addr/req_ready  fetch request to the MMU (req_addr = fetch_pc)
//   resp_valid/resp_data/resp_fault  in-order response: aligned 8-byte word plus fault flag
//   out_valid/out_inst/out_pc/out_fault/out_ready  queue head towards decode
//   fetch_pc                    next PC to request
module fetch_buf #(
  parameter logic [63:0] PC_INIT = 64'h8000_0000,
  parameter int          DEPTH   = 4,
  parameter int          MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        req_valid,
  output logic [63:0] req_addr,
  input  logic        req_ready,
  input  logic        resp_valid,
  input  logic [63:0] resp_data,
  input  logic        resp_fault,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [63:0] out_pc,
  output logic        out_fault,
  input  logic        out_ready,
  output logic [63:0] fetch_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        fault;
  } qent_t;

  logic [63:0]   fetch_pc_q, fetch_pc_d;
  qent_t         queue_q [DEPTH];
  qent_t         queue_d [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   tag_q [MAX_OUT];
  logic [63:0]   tag_d [MAX_OUT];
  logic [TW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d, drop_q, drop_d;
  logic          halted_q, halted_d;

  logic          accept, keep, pop;
  logic [63:0]   resp_pc;
  logic [CW:0]   credit_used;
  logic [1:0]    unused_redirect_lsb;

  // Tag FIFO depth need not be a power of two, so wrap explicitly.
  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUT - 1)) ? '0 : p + TW'(1);
  endfunction

  assign unused_redirect_lsb = redirect_pc[1:0];

  // Outstanding requests (including ones destined to be dropped) reserve a
  // queue slot, so every response is guaranteed room.
  assign credit_used = (CW+1)'(count_q) + (CW+1)'(out_cnt_q);
  assign req_valid   = !rst && !redirect_valid && !halted_q &&
                       (out_cnt_q < OW'(MAX_OUT)) && (credit_used < (CW+1)'(DEPTH));
  assign req_addr    = fetch_pc_q;
  assign fetch_pc    = fetch_pc_q;

  assign out_valid = (count_q != '0);
  assign out_inst  = out_valid ? queue_q[head_q].inst  : '0;
  assign out_pc    = out_valid ? queue_q[head_q].pc    : '0;
  assign out_fault = out_valid ? queue_q[head_q].fault : 1'b0;

  assign accept  = req_valid && req_ready;
  assign resp_pc = tag_q[tag_rd_q];
  assign keep    = resp_valid && (drop_q == '0) && !redirect_valid;
  assign pop     = out_valid && out_ready && !redirect_valid;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    queue_d    = queue_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    tag_d      = tag_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;
    out_cnt_d  = out_cnt_q + OW'(accept) - OW'(resp_valid);
    drop_d     = drop_q;
    halted_d   = halted_q;

    if (accept) begin
      tag_d[tag_wr_q] = fetch_pc_q;
      tag_wr_d        = tag_inc(tag_wr_q);
      fetch_pc_d      = fetch_pc_q + 64'd4;
    end
    // Every response retires the oldest tag, kept or dropped.
    if (resp_valid) begin
      tag_rd_d = tag_inc(tag_rd_q);
    end

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[63:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      halted_d   = 1'b0;
      // No accept can happen this cycle, so this is everything still in flight.
      drop_d     = out_cnt_d;
    end else begin
      if (resp_valid && (drop_q != '0)) begin
        drop_d = drop_q - OW'(1);
      end
      if (keep) begin
        queue_d[tail_q] = '{inst:  resp_pc[2] ? resp_data[63:32] : resp_data[31:0],
                            pc:    resp_pc,
                            fault: resp_fault};
        tail_d = tail_q + AW'(1);
        if (resp_fault) begin
          halted_d = 1'b1;
        end
      end
      if (pop) begin
        head_d = head_q + AW'(1);
      end
      count_d = count_q + CW'(keep) - CW'(pop);
    end
  end

  // Storage arrays carry no reset; validity comes from count_q / out_cnt_q.
  always_ff @(posedge clk) begin
    queue_q <= queue_d;
    tag_q   <= tag_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= PC_INIT;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
      out_cnt_q  <= '0;
      drop_q     <= '0;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
      out_cnt_q  <= out_cnt_d;
      drop_q     <= drop_d;
      halted_q   <= halted_d;
    end
  end

  // Memory may only answer requests it has accepted.
  assert property (@(posedge clk) disable iff (rst) resp_valid |-> (out_cnt_q != '0));

endmodule

// File: tb/tb_fetch_buf.sv
module tb_fetch_buf;
  localparam logic [63:0] PC_INIT = 64'h8000_0000;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_fault;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        out_fault;
  logic        out_ready;
  logic [63:0] fetch_pc;

  always #5 clk = ~clk;

  fetch_buf #(.PC_INIT(PC_INIT), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_fault(out_fault),
    .out_ready(out_ready), .fetch_pc(fetch_pc)
  );

  // Reference model: requests in flight carry the epoch they were issued in;
  // a redirect starts a new epoch and anything older is never delivered.
  typedef struct { logic [63:0] pc; int epoch; int cyc; } req_t;
  typedef struct { logic [63:0] pc; logic [31:0] inst; logic fault; } item_t;

  req_t        pend[$];
  item_t       mq[$];
  logic [63:0] m_fetch_pc;
  int          m_epoch;
  bit          m_halted;
  int          cyc;
  logic [63:0] fault_addr;
  bit          rand_faults;
  int          checks;
  int          errors;

  bit          t_redir, t_req_ready, t_out_ready, t_resp_en;
  logic [63:0] t_redir_pc;

  bit          exp_req_valid, exp_out_valid;
  logic [63:0] exp_req_addr;
  item_t       exp_head;
  logic        obs_req_valid, obs_out_valid, obs_out_fault;
  logic [63:0] obs_req_addr, obs_fetch_pc, obs_out_pc;
  logic [31:0] obs_out_inst;

  function automatic logic [63:0] mem_word(input logic [63:0] addr);
    logic [63:0] a;
    a = {addr[63:3], 3'b000};
    if (a == 64'h8000_0000) return 64'h0000_0013_0010_0093;
    if (a == 64'h8000_0008) return 64'h0000_0073_0020_0113;
    return {a[31:0] ^ 32'h5A5A_0001, ~a[34:3] ^ a[63:32]};
  endfunction

  function automatic bit is_fault(input logic [63:0] addr);
    return (addr == fault_addr) || (rand_faults && addr[7:2] == 6'h2B);
  endfunction

  // One clock cycle: drive knobs, sample outputs, advance the model. Starts and ends at a negedge.
  task automatic tick();
    bit          fire, kept;
    logic [63:0] w;
    req_t        r;
    item_t       it;
    fire = t_resp_en && pend.size() > 0 && pend[0].cyc < cyc;
    kept = 1'b0;
    w    = '0;
    redirect_valid = t_redir;
    redirect_pc    = t_redir_pc;
    req_ready      = t_req_ready;
    out_ready      = t_out_ready;
    if (fire) begin
      w          = mem_word(pend[0].pc);
      resp_valid = 1'b1;
      resp_data  = w;
      resp_fault = is_fault(pend[0].pc);
    end else begin
      resp_valid = 1'b0;
      resp_data  = {$urandom, $urandom};
      resp_fault = 1'($urandom_range(0, 1));
    end
    #1;
    exp_req_valid = !t_redir && !m_halted && pend.size() < MAX_OUT && (mq.size() + pend.size() < DEPTH);
    exp_req_addr  = m_fetch_pc;
    exp_out_valid = mq.size() > 0;
    if (exp_out_valid) exp_head = mq[0];
    obs_req_valid = req_valid;
    obs_req_addr  = req_addr;
    obs_fetch_pc  = fetch_pc;
    obs_out_valid = out_valid;
    obs_out_pc    = out_pc;
    obs_out_inst  = out_inst;
    obs_out_fault = out_fault;

    if (fire) begin
      r = pend.pop_front();
      if (!t_redir && r.epoch == m_epoch) begin
        it.pc    = r.pc;
        it.inst  = r.pc[2] ? w[63:32] : w[31:0];
        it.fault = is_fault(r.pc);
        kept     = 1'b1;
      end
    end
    if (t_redir) begin
      mq.delete();
      m_epoch++;
      m_fetch_pc = {t_redir_pc[63:2], 2'b00};
      m_halted   = 1'b0;
    end else begin
      if (exp_out_valid && t_out_ready) void'(mq.pop_front());
      if (kept) begin
        mq.push_back(it);
        if (it.fault) m_halted = 1'b1;
      end
    end
    if (exp_req_valid && t_req_ready) begin
      r.pc = m_fetch_pc; r.epoch = m_epoch; r.cyc = cyc;
      pend.push_back(r);
      m_fetch_pc = m_fetch_pc + 64'd4;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_assert(input int n);
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; req_ready = 1'b0;
    out_ready = 1'b0; resp_valid = 1'b0; resp_data = '0; resp_fault = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_release();
    rst = 1'b0;
    pend.delete(); mq.delete();
    m_fetch_pc = PC_INIT; m_halted = 1'b0; m_epoch++;
    fault_addr = '1; rand_faults = 1'b0;
    t_redir = 1'b0; t_redir_pc = '0; t_req_ready = 1'b0; t_out_ready = 1'b0; t_resp_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_assert(2);
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", req_valid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_inst !== 32'h0 || out_pc !== 64'h0 || out_fault !== 1'b0) begin errors++; $display("FAIL reset_out_fields got inst=%h pc=%h fault=%b want 0", out_inst, out_pc, out_fault); end
    checks++; if (fetch_pc !== PC_INIT || req_addr !== PC_INIT) begin errors++; $display("FAIL reset_fetch_pc got %h/%h want %h", fetch_pc, req_addr, PC_INIT); end
    reset_release();
  endtask

  task automatic test_stream();
    logic [63:0] want_pc [4];
    logic [31:0] want_inst [4];
    int n;
    want_pc   = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008, 64'h8000_000C};
    want_inst = '{32'h0010_0093, 32'h0000_0013, 32'h0020_0113, 32'h0000_0073};
    n = 0;
    reset_assert(1); reset_release();
    t_req_ready = 1'b1; t_resp_en = 1'b1; t_out_ready = 1'b1;
    for (int c = 0; c < 30 && n < 4; c++) begin
      tick();
      if (c == 0) begin
        checks++; if (obs_req_valid !== 1'b1 || obs_req_addr !== PC_INIT) begin errors++; $display("FAIL stream_first_req got v=%b a=%h want 1 %h", obs_req_valid, obs_req_addr, PC_INIT); end
      end
      if (obs_out_valid === 1'b1) begin
        checks++; if (obs_out_pc !== want_pc[n] || obs_out_inst !== want_inst[n]) begin errors++; $display("FAIL stream_item%0d got pc=%h inst=%h want pc=%h inst=%h", n, obs_out_pc, obs_out_inst, want_pc[n], want_inst[n]); end
        checks++; if (c != n + 2) begin errors++; $display("FAIL stream_timing%0d got cycle %0d want %0d", n, c, n + 2); end
        n++;
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL stream_count got %0d want 4", n); end
  endtask

  task automatic test_backpressure();
    int n_acc;
    reset_assert(1); reset_release();
    t_req_ready = 1'b1; t_resp_en = 1'b1; t_out_ready = 1'b0;
    repeat (10) tick();
    checks++; if (obs_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid got %b want 0", obs_req_valid); end
    checks++; if (obs_fetch_pc !== 64'h8000_0010) begin errors++; $display("FAIL bp_fetch_pc got %h want 80000010", obs_fetch_pc); end
    checks++; if (obs_out_valid !== 1'b1 || obs_out_pc !== PC_INIT) begin errors++; $display("FAIL bp_head got v=%b pc=%h want 1 %h", obs_out_valid, obs_out_pc, PC_INIT); end
    n_acc = 0;
    t_out_ready = 1'b1;
    tick();
    if (obs_req_valid === 1'b1) n_acc++;
    t_out_ready = 1'b0;
    repeat (10) begin
      tick();
      if (obs_req_valid === 1'b1) n_acc++;
    end
    checks++; if (n_acc != 1) begin errors++; $display("FAIL bp_one_request got %0d want 1", n_acc); end
    checks++; if (obs_fetch_pc !== 64'h8000_0014) begin errors++; $display("FAIL bp_fetch_pc_after got %h want 80000014", obs_fetch_pc); end
  endtask

  task automatic test_redirect_drop();
    bit first_req, got_out;
    reset_assert(1); reset_release();
    t_req_ready = 1'b1; t_resp_en = 1'b0; t_out_ready = 1'b1;
    tick(); tick();
    t_redir = 1'b1; t_redir_pc = 64'h8000_0100;
    tick();
    t_redir = 1'b0; t_resp_en = 1'b1;
    checks++; if (dut.drop_q !== 2'd2) begin errors++; $display("FAIL rd_drop_count got %0d want 2", dut.drop_q); end
    first_req = 1'b1; got_out = 1'b0;
    for (int c = 0; c < 20 && !got_out; c++) begin
      tick();
      if (obs_req_valid === 1'b1 && first_req) begin
        first_req = 1'b0;
        checks++; if (obs_req_addr !== 64'h8000_0100) begin errors++; $display("FAIL rd_first_req got %h want 80000100", obs_req_addr); end
      end
      if (c < 3) begin
        checks++; if (obs_out_valid !== 1'b0) begin errors++; $display("FAIL rd_dropped c%0d got out_valid %b want 0", c, obs_out_valid); end
      end else if (obs_out_valid === 1'b1) begin
        got_out = 1'b1;
        checks++; if (obs_out_pc !== 64'h8000_0100) begin errors++; $display("FAIL rd_first_out got %h want 80000100", obs_out_pc); end
      end
    end
    checks++; if (!got_out) begin errors++; $display("FAIL rd_timeout got no output want one"); end
  endtask

  task automatic test_fault();
    int n;
    reset_assert(1); reset_release();
    fault_addr = 64'h8000_0004;
    t_req_ready = 1'b1; t_resp_en = 1'b1; t_out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      tick();
      if (obs_out_valid === 1'b1) begin
        checks++; if (obs_out_pc !== PC_INIT + 64'(4 * n) || obs_out_fault !== 1'(n)) begin errors++; $display("FAIL fault_item%0d got pc=%h f=%b want pc=%h f=%0d", n, obs_out_pc, obs_out_fault, PC_INIT + 64'(4 * n), n); end
        n++;
      end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL fault_count got %0d want 2", n); end
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (obs_req_valid !== 1'b0) begin errors++; $display("FAIL fault_halt c%0d got req_valid %b want 0", c, obs_req_valid); end
    end
    t_redir = 1'b1; t_redir_pc = 64'h8000_0200;
    tick();
    t_redir = 1'b0;
    tick();
    checks++; if (obs_req_valid !== 1'b1 || obs_req_addr !== 64'h8000_0200) begin errors++; $display("FAIL fault_restart got v=%b a=%h want 1 80000200", obs_req_valid, obs_req_addr); end
    checks++; if (obs_out_valid !== 1'b0) begin errors++; $display("FAIL fault_flush got out_valid %b want 0", obs_out_valid); end
  endtask

  task automatic test_redirect_resp_pop();
    bit got_out;
    reset_assert(1); reset_release();
    t_req_ready = 1'b1; t_resp_en = 1'b1; t_out_ready = 1'b0;
    tick(); tick();
    t_resp_en = 1'b0;
    tick();
    t_redir = 1'b1; t_redir_pc = 64'h8000_0300; t_resp_en = 1'b1; t_out_ready = 1'b1;
    tick();
    checks++; if (obs_out_valid !== 1'b1) begin errors++; $display("FAIL rrp_head_before got %b want 1", obs_out_valid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rrp_flushed got out_valid %b want 0", out_valid); end
    checks++; if (dut.drop_q !== 2'd1 || dut.out_cnt_q !== 2'd1) begin errors++; $display("FAIL rrp_drop got drop=%0d out=%0d want 1 1", dut.drop_q, dut.out_cnt_q); end
    t_redir = 1'b0;
    got_out = 1'b0;
    for (int c = 0; c < 20 && !got_out; c++) begin
      tick();
      if (obs_out_valid === 1'b1) begin
        got_out = 1'b1;
        checks++; if (obs_out_pc !== 64'h8000_0300) begin errors++; $display("FAIL rrp_first_out got %h want 80000300", obs_out_pc); end
      end
    end
    checks++; if (!got_out) begin errors++; $display("FAIL rrp_timeout got no output want one"); end
  endtask

  task automatic test_reset_midstream();
    reset_assert(1); reset_release();
    t_req_ready = 1'b1; t_resp_en = 1'b1; t_out_ready = 1'b0;
    tick(); tick(); tick();
    t_resp_en = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_busy got out_valid %b want 1", out_valid); end
    reset_assert(1);
    checks++; if (req_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_valids got req=%b out=%b want 0 0", req_valid, out_valid); end
    checks++; if (out_inst !== 32'h0 || out_pc !== 64'h0 || out_fault !== 1'b0) begin errors++; $display("FAIL mid_out_fields got inst=%h pc=%h f=%b want 0", out_inst, out_pc, out_fault); end
    checks++; if (fetch_pc !== PC_INIT || req_addr !== PC_INIT) begin errors++; $display("FAIL mid_fetch_pc got %h/%h want %h", fetch_pc, req_addr, PC_INIT); end
    checks++; if (dut.out_cnt_q !== 2'd0 || dut.drop_q !== 2'd0) begin errors++; $display("FAIL mid_counters got out=%0d drop=%0d want 0 0", dut.out_cnt_q, dut.drop_q); end
    reset_release();
    t_req_ready = 1'b1;
    tick();
    checks++; if (obs_req_valid !== 1'b1 || obs_req_addr !== PC_INIT) begin errors++; $display("FAIL mid_restart got v=%b a=%h want 1 %h", obs_req_valid, obs_req_addr, PC_INIT); end
  endtask

  task automatic test_random();
    reset_assert(1); reset_release();
    rand_faults = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      t_req_ready = ($urandom_range(0, 3) != 0);
      t_out_ready = ($urandom_range(0, 3) != 0);
      t_resp_en   = ($urandom_range(0, 2) != 0);
      t_redir     = ($urandom_range(0, 40) == 0);
      case ($urandom_range(0, 3))
        0, 1:    t_redir_pc = 64'h8000_0000 + 64'($urandom_range(0, 4095));
        2:       t_redir_pc = 64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(0, 31));
        default: t_redir_pc = {$urandom, $urandom};
      endcase
      tick();
      checks++; if (obs_req_valid !== exp_req_valid) begin errors++; if (errors < 30) $display("FAIL rnd_req_valid c%0d got %b want %b", c, obs_req_valid, exp_req_valid); end
      if (!t_redir) begin
        checks++; if (obs_fetch_pc !== exp_req_addr || obs_req_addr !== exp_req_addr) begin errors++; if (errors < 30) $display("FAIL rnd_fetch_pc c%0d got %h/%h want %h", c, obs_fetch_pc, obs_req_addr, exp_req_addr); end
      end
      checks++; if (obs_out_valid !== exp_out_valid) begin errors++; if (errors < 30) $display("FAIL rnd_out_valid c%0d got %b want %b", c, obs_out_valid, exp_out_valid); end
      if (exp_out_valid) begin
        checks++; if (obs_out_pc !== exp_head.pc || obs_out_inst !== exp_head.inst || obs_out_fault !== exp_head.fault) begin errors++; if (errors < 30) $display("FAIL rnd_head c%0d got pc=%h i=%h f=%b want pc=%h i=%h f=%b", c, obs_out_pc, obs_out_inst, obs_out_fault, exp_head.pc, exp_head.inst, exp_head.fault); end
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; m_epoch = 0;
    fault_addr = '1; rand_faults = 1'b0;
    t_redir = 1'b0; t_redir_pc = '0; t_req_ready = 1'b0; t_out_ready = 1'b0; t_resp_en = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_fault();
    test_redirect_resp_pop();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no completion want finish within 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
